// File: rtl/midi_note_serializer.sv
// MIDI byte-stream parser, event FIFO and 14-bit serial word shifter for the piano key-drive link.
// Optional macro SUSTAIN_EN: accept CC64 (sustain) and report it on the top key index.
module midi_note_serializer #(
    parameter int CHANNEL      = 16,
    parameter int LOW_NOTE     = 21,
    parameter int NUM_KEYS     = 12,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 8,
    parameter int GAP_CYCLES   = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          sr_clk,
    output logic                          sr_d,
    output logic                          sr_latch,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SUSTAIN_EN
    localparam int NOTE_KEYS = NUM_KEYS - 1;
`else
    localparam int NOTE_KEYS = NUM_KEYS;
`endif
    localparam int MAX_A   = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // rx_valid is a one-cycle strobe with no back-pressure: every strobed byte is consumed.
    logic [7:0]  status_q, status_d;
    logic        dcnt_q, dcnt_d;
    logic [6:0]  d1_q, d1_d;
    logic        ev_valid_q, ev_valid_d;
    logic [13:0] ev_word_q, ev_word_d;

    logic        msg_done;
    logic        one_byte;
    logic        chan_ok;
    logic        note_ok;
    logic [6:0]  note_key;

    assign one_byte = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
    assign chan_ok  = (CHANNEL >= 16) || (status_q[3:0] == 4'(CHANNEL));
    assign note_ok  = (int'(d1_q) >= LOW_NOTE) && (int'(d1_q) < LOW_NOTE + NOTE_KEYS);
    assign note_key = 7'(int'(d1_q) - LOW_NOTE);

    always_comb begin
        status_d   = status_q;
        dcnt_d     = dcnt_q;
        d1_d       = d1_q;
        ev_valid_d = 1'b0;
        ev_word_d  = ev_word_q;
        msg_done   = 1'b0;
        if (rx_valid && (rx_data[7:3] != 5'b11111)) begin
            if (rx_data[7:4] == 4'hF) begin
                status_d = 8'h00;
                dcnt_d   = 1'b0;
            end else if (rx_data[7]) begin
                status_d = rx_data;
                dcnt_d   = 1'b0;
            end else if (status_q[7]) begin
                if (!dcnt_q) begin
                    d1_d = rx_data[6:0];
                end
                if (dcnt_q || one_byte) begin
                    dcnt_d   = 1'b0;
                    msg_done = dcnt_q;
                end else begin
                    dcnt_d = 1'b1;
                end
            end
        end
        // Only two-byte messages can be accepted, so d1_q holds the first data byte here.
        if (msg_done && chan_ok) begin
            case (status_q[7:4])
                4'h8, 4'h9: begin
                    if (note_ok) begin
                        ev_valid_d = 1'b1;
                        ev_word_d  = {note_key, status_q[4] ? rx_data[6:0] : 7'd0};
                    end
                end
`ifdef SUSTAIN_EN
                4'hB: begin
                    if (d1_q == 7'd64) begin
                        ev_valid_d = 1'b1;
                        ev_word_d  = {7'(NUM_KEYS - 1), rx_data[6] ? 7'h7F : 7'h00};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    logic [13:0] mem_q [FIFO_DEPTH];
    logic [13:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          pop;
    logic          push;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          phase_q, phase_d;
    logic [13:0]   word_q, word_d;
    logic          sr_clk_q, sr_clk_d;
    logic          sr_d_q, sr_d_d;
    logic          sr_latch_q, sr_latch_d;

    // A full FIFO still accepts a push in the cycle the serializer pops it.
    assign pop  = (state_q == S_IDLE) && (level_q != '0);
    assign push = ev_valid_q && ((level_q != FULL_LVL) || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = ev_valid_q && !push;
        if (push) begin
            mem_d[wr_ptr_q] = ev_word_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SHIFT;
                    word_d  = mem_q[rd_ptr_q];
                    bit_d   = 4'd13;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d = S_LATCH;
                        end else begin
                            bit_d = bit_q - 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Link outputs are registered from next-state so they are glitch-free.
        sr_clk_d   = (state_d == S_SHIFT) && phase_d;
        sr_d_d     = (state_d == S_SHIFT) && word_d[bit_d];
        sr_latch_d = (state_d == S_LATCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= 8'h00;
            dcnt_q     <= 1'b0;
            d1_q       <= 7'd0;
            ev_valid_q <= 1'b0;
            ev_word_q  <= 14'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 14'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            phase_q    <= 1'b0;
            word_q     <= 14'd0;
            sr_clk_q   <= 1'b0;
            sr_d_q     <= 1'b0;
            sr_latch_q <= 1'b0;
        end else begin
            status_q   <= status_d;
            dcnt_q     <= dcnt_d;
            d1_q       <= d1_d;
            ev_valid_q <= ev_valid_d;
            ev_word_q  <= ev_word_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            word_q     <= word_d;
            sr_clk_q   <= sr_clk_d;
            sr_d_q     <= sr_d_d;
            sr_latch_q <= sr_latch_d;
        end
    end

    assign sr_clk     = sr_clk_q;
    assign sr_d       = sr_d_q;
    assign sr_latch   = sr_latch_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: doc/midi_note_serializer.md
Name: midi_note_serializer

Overview:
- Upstream stage of the piano key-drive block: parses a MIDI byte stream from the UART receiver into note events.
- Queues those events in a small FIFO.
- Shifts each event out as a 14-bit word, MSB first, on the sr_clk / sr_d / sr_latch link consumed by the piano block.
- Word format: [13:7] key index, [6:0] velocity (0 = key off).

Parameters:
- CHANNEL, 16, MIDI channel 0-15 to accept; 16 = omni.
- LOW_NOTE, 21, MIDI note number mapped to key index 0.
- NUM_KEYS, 12, number of keys; note numbers outside LOW_NOTE..LOW_NOTE+NUM_KEYS-1 are discarded.
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- CLK_DIV, 4, clk cycles per half-period of sr_clk; minimum 1.
- LATCH_CYCLES, 8, clk cycles sr_latch is held high per word.
- GAP_CYCLES, 512, minimum idle clk cycles after latch falls, so the downstream write pass can finish.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received MIDI byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- sr_clk  out  1  serial clock; downstream samples sr_d on its rising edge
- sr_d  out  1  serial data
- sr_latch  out  1  word-complete strobe
- busy  out  1  high when the serializer is not in IDLE or the FIFO is non-empty
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; running status cleared; data-byte counter 0; FIFO empty; serializer in IDLE. Reset mid-word abandons the word; no latch pulse is issued.
- Parser rules; only cycles with rx_valid high are processed:
  - Bytes 0xF8-0xFF (real-time): ignored. Running status and partial data are untouched.
  - Bytes 0xF0-0xF7 (system common): clear running status. Following data bytes are ignored until the next channel status.
  - Bytes 0x80-0xEF (channel status): store as running status and reset the data-byte counter. Expected data length is 1 for 0xCn and 0xDn, 2 otherwise. The message is "accepted" only if it is 0x8n, 0x9n (or 0xBn when SUSTAIN_EN is defined) and n matches CHANNEL (or CHANNEL = 16).
  - Data bytes (bit 7 = 0): with no running status, ignore. Otherwise store as d1 or d2. When the expected length is reached, the counter returns to 0 (running status is kept) and the message is evaluated if accepted.
- Event generation:
  - 0x9n with d2 > 0: push {d1-LOW_NOTE, d2}.
  - 0x8n, or 0x9n with d2 = 0: push {d1-LOW_NOTE, 0}.
  - Out-of-range notes produce no push.
- Push timing: the push occurs on the clk edge after the completing data byte is sampled. If the FIFO is full, the event is dropped and overflow pulses on that same edge.
- Simultaneous push and pop is allowed when full or empty as long as the pop is legal. fifo_level is unchanged in that case.
- Serializer states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head word, go to SHIFT with bit index 13. Pop-to-first-sr_d latency is 1 cycle.
  - SHIFT: for each bit, sr_d = word[idx] and sr_clk = 0 for CLK_DIV cycles, then sr_clk = 1 for CLK_DIV cycles. sr_d is held stable through the high phase. After bit 0's high phase, sr_clk returns to 0 and the state goes to LATCH.
  - LATCH: sr_latch = 1 for LATCH_CYCLES cycles; sr_d = 0 and sr_clk = 0. Then go to GAP.
  - GAP: sr_latch = 0 for GAP_CYCLES cycles, then go to IDLE.
- Word spacing: minimum start-to-start spacing is 28*CLK_DIV + LATCH_CYCLES + GAP_CYCLES + 1 cycles.
- sr_clk changes only in SHIFT. sr_d changes only while sr_clk is low.

Optional Feature:
- Macro: SUSTAIN_EN.
- Defined:
  - Channel 0xBn with d1 = 64 is accepted.
  - d2 >= 64 pushes {NUM_KEYS-1, 127}; d2 < 64 pushes {NUM_KEYS-1, 0}.
  - The top key index is reserved for the pedal. Note numbers are then valid only up to LOW_NOTE+NUM_KEYS-2.
- Undefined:
  - 0xBn is parsed for length only and never pushes.
  - All NUM_KEYS indices are notes.

Test Plan:
- Bytes 0x90,0x18,0x40 (CHANNEL=16, LOW_NOTE=21) -> one word 0x01C0 (key 3, vel 64) shifted MSB first. sr_clk shows 14 rising edges, then sr_latch high 8 cycles, then GAP.
- Running status: 0x90,0x15,0x7F,0x15,0x00 -> words {0,127} then {0,0}. The second word starts no earlier than the minimum word spacing after the first.
- Filtering: 0x91,0x15,0x40 with CHANNEL=0 -> nothing pushed. Also 0x90,0x14,0x40 and 0x90,0x21,0x40 (both out of range) -> nothing pushed.
- Interleaved real-time: 0x90,0xF8,0x16,0xFE,0x50 -> word {1,80}. 0x90,0x16,0xF0,0x50 -> no word.
- Overflow: 10 note-ons within 100 cycles, FIFO_DEPTH=8 -> one word starts immediately and eight queue, so fifo_level reaches 8. Exactly one overflow pulse occurs; 9 words are emitted in order.
- Reset: assert rst_n low during bit 6 of a word -> all outputs 0 immediately, no latch pulse. After release, the next note-on is emitted cleanly. With SUSTAIN_EN defined, 0xB0,0x40,0x7F -> word {11,127}.
